// File: rtl/sap1_controller.sv
// SAP-1 control unit: fetch/decode/execute sequencer that owns PC, IR,
// accumulator and output register, reading a 16x8 ROM over a registered
// read port (data returns one cycle after mem_re).
module sap1_controller #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDRESS_SIZE = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    run,
   output logic                    mem_re,
   output logic [ADDRESS_SIZE-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0]   mem_data,
   output logic [DATA_WIDTH-1:0]   acc,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    out_valid,
   output logic                    busy,
   output logic                    halted
);

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LATCH, S_OPFETCH, S_EXEC, S_OUTPUT, S_HALT
   } state_t;

   state_t                  state, nxt;
   logic [ADDRESS_SIZE-1:0] pc;
   logic [DATA_WIDTH-1:0]   ir;

   // opcode of the word arriving from ROM and of the latched instruction
   logic [3:0] mem_op, ir_op;
   assign mem_op = mem_data[DATA_WIDTH-1 -: 4];
   assign ir_op  = ir[DATA_WIDTH-1 -: 4];

   // ROM port and status are pure decodes of registered state
   assign mem_re   = (state == S_FETCH) || (state == S_OPFETCH);
   assign mem_addr = (state == S_OPFETCH) ? ir[ADDRESS_SIZE-1:0] : pc;
   assign busy     = (state != S_IDLE) && (state != S_HALT);
   assign halted   = (state == S_HALT);

   // state register plus datapath updates; each register only moves in the
   // one state that owns it, so a reset mid-instruction leaves nothing partial
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         pc        <= '0;
         ir        <= '0;
         acc       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= nxt;
         out_valid <= 1'b0;
         case (state)
            S_LATCH: begin
               ir <= mem_data;
               pc <= pc + 1'b1;  // wraps 15 -> 0
            end
            S_EXEC: begin
               case (ir_op)
                  OP_LDA:  acc <= mem_data;
                  OP_ADD:  acc <= acc + mem_data;
                  OP_SUB:  acc <= acc - mem_data;
                  default: acc <= acc;
               endcase
            end
            S_OUTPUT: begin
               out_data  <= acc;
               out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // next-state decode; LATCH dispatches on the opcode as it arrives from ROM
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:    if (run) nxt = S_FETCH;
         S_FETCH:   nxt = S_LATCH;
         S_LATCH: begin
            case (mem_op)
               OP_LDA, OP_ADD, OP_SUB: nxt = S_OPFETCH;
               OP_OUT:                 nxt = S_OUTPUT;
               OP_HLT:                 nxt = S_HALT;
               default:                nxt = S_FETCH;  // unknown opcode acts as NOP
            endcase
         end
         S_OPFETCH: nxt = S_EXEC;
         S_EXEC:    nxt = S_FETCH;
         S_OUTPUT:  nxt = S_FETCH;
         S_HALT:    nxt = S_HALT;
         default:   nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller: an instruction-level interpreter
// predicts every ROM read (cycle, address), every output pulse (cycle, value)
// and the halt cycle; a negedge monitor compares the DUT against those queues.
module tb_sap1_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       mem_re;
   logic [3:0] mem_addr;
   logic [7:0] mem_data = '0;
   logic [7:0] acc, out_data;
   logic       out_valid, busy, halted;

   sap1_controller #(.DATA_WIDTH(8), .ADDRESS_SIZE(4)) dut (
      .clk(clk), .rst(rst), .run(run),
      .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data),
      .acc(acc), .out_data(out_data), .out_valid(out_valid),
      .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   // ROM with registered read
   logic [7:0] rom [16];
   always @(posedge clk) if (mem_re) mem_data <= rom[mem_addr];

   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   typedef struct { int cyc; int val; } ev_t;
   ev_t re_q[$];
   ev_t out_q[$];
   int  halt_cyc;
   int  exp_acc;
   int  start;
   bit  mon_en = 1'b0;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Instruction-level interpreter. Cycle 1 is the FETCH after the edge that
   // samples run; costs: LDA/ADD/SUB 4, OUT 3, NOP 2, HLT halted 2 after fetch.
   task automatic build_model(input int maxc);
      int t, pc, acc_m;
      logic [7:0] w;
      re_q.delete();
      out_q.delete();
      t = 1; pc = 0; acc_m = 0; halt_cyc = -1;
      while (t <= maxc && halt_cyc < 0) begin
         w = rom[pc];
         re_q.push_back('{t, pc});
         pc = (pc + 1) % 16;
         case (w[7:4])
            4'h0, 4'h1, 4'h2: begin
               if (t + 2 <= maxc) re_q.push_back('{t + 2, int'(w[3:0])});
               if (w[7:4] == 4'h0)      acc_m = rom[w[3:0]];
               else if (w[7:4] == 4'h1) acc_m = (acc_m + rom[w[3:0]]) % 256;
               else                     acc_m = (acc_m - rom[w[3:0]] + 256) % 256;
               t += 4;
            end
            4'hE: begin
               if (t + 3 <= maxc) out_q.push_back('{t + 3, acc_m});
               t += 3;
            end
            4'hF: halt_cyc = t + 2;
            default: t += 2;
         endcase
      end
      exp_acc = acc_m;
   endtask

   // monitor: pop and compare on every ROM read and output pulse
   always @(negedge clk) begin
      int cyc;
      bit hexp;
      ev_t e;
      if (mon_en) begin
         cyc = edges - start;
         if (mem_re) begin
            if (re_q.size() == 0) chk("unexpected_mem_re", 1, 0);
            else begin
               e = re_q.pop_front();
               chk("mem_re_cycle", cyc, e.cyc);
               chk("mem_addr", int'(mem_addr), e.val);
            end
         end
         if (out_valid) begin
            if (out_q.size() == 0) chk("unexpected_out_valid", 1, 0);
            else begin
               e = out_q.pop_front();
               chk("out_cycle", cyc, e.cyc);
               chk("out_data", int'(out_data), e.val);
            end
         end
         if (cyc >= 1) begin
            hexp = (halt_cyc >= 0) && (cyc >= halt_cyc);
            chk("halted", int'(halted), int'(hexp));
            chk("busy", int'(busy), int'(!hexp));
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      mon_en = 1'b0;
      rst = 1'b1;
      run = 1'b0;
      @(negedge clk);
      chk("rst_acc", int'(acc), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_mem_re", int'(mem_re), 0);
      rst = 1'b0;
   endtask

   // pulse run, then let the monitor see cycles 1..maxc
   task automatic run_prog(input int maxc);
      build_model(maxc);
      @(negedge clk);
      run = 1'b1;
      start = edges;
      mon_en = 1'b1;
      @(negedge clk);
      run = 1'b0;
      while (edges - start < maxc) @(negedge clk);
      #1;
   endtask

   task automatic end_prog(input string nm);
      mon_en = 1'b0;
      chk({nm, "_re_left"}, re_q.size(), 0);
      chk({nm, "_out_left"}, out_q.size(), 0);
      if (halt_cyc >= 0) chk({nm, "_acc"}, int'(acc), exp_acc);
   endtask

   task automatic load_default();
      foreach (rom[i]) rom[i] = 8'h00;
      rom[0] = 8'h09; rom[1] = 8'h1A; rom[2] = 8'h1B; rom[3] = 8'h2C;
      rom[4] = 8'hE0; rom[5] = 8'h09; rom[6] = 8'h1C; rom[7] = 8'hE0;
      rom[8] = 8'hF0;
      rom[9] = 8'd1; rom[10] = 8'd2; rom[11] = 8'd3; rom[12] = 8'd4;
   endtask

   initial begin
      logic [7:0] acc0, od0;
      int r;
      logic [3:0] op, lo;

      // default program, then run toggling while halted
      do_reset();
      load_default();
      run_prog(33);
      chk("t1_halt_out_data", int'(out_data), 5);
      acc0 = acc; od0 = out_data;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         run = ~run;
      end
      @(negedge clk);
      run = 1'b0;
      #1;
      chk("t6_acc_stable", int'(acc), int'(acc0));
      chk("t6_out_stable", int'(out_data), int'(od0));
      end_prog("t1");

      // wrap-around of add and subtract
      do_reset();
      foreach (rom[i]) rom[i] = 8'h00;
      rom[0] = 8'h0D; rom[1] = 8'h1E; rom[2] = 8'hE0; rom[3] = 8'h2E;
      rom[4] = 8'hE0; rom[5] = 8'hF0; rom[13] = 8'hFF; rom[14] = 8'h01;
      run_prog(25);
      chk("t2_acc_ff", int'(acc), 255);
      end_prog("t2");

      // unknown opcode then HLT
      do_reset();
      foreach (rom[i]) rom[i] = 8'h77;
      rom[0] = 8'h5A; rom[1] = 8'hF3;
      run_prog(12);
      chk("t3_acc_zero", int'(acc), 0);
      end_prog("t3");

      // sixteen NOPs: PC wraps back to 0, never halts
      do_reset();
      foreach (rom[i]) rom[i] = {4'h3 + 4'(i % 8), 4'(i)};
      run_prog(40);
      end_prog("t4");

      // reset during OPFETCH of ADD, then restart
      do_reset();
      load_default();
      run_prog(7);
      chk("t5_pre_acc", int'(acc), 1);
      end_prog("t5a");
      rst = 1'b1;
      @(negedge clk);
      chk("t5_acc", int'(acc), 0);
      chk("t5_mem_re", int'(mem_re), 0);
      chk("t5_busy", int'(busy), 0);
      chk("t5_halted", int'(halted), 0);
      rst = 1'b0;
      run_prog(33);
      end_prog("t5b");

      // randomized programs
      for (int k = 0; k < 10; k++) begin
         do_reset();
         foreach (rom[i]) begin
            r = $urandom_range(0, 19);
            if (r < 4)       op = 4'h0;
            else if (r < 8)  op = 4'h1;
            else if (r < 11) op = 4'h2;
            else if (r < 15) op = 4'hE;
            else if (r < 16) op = 4'hF;
            else             op = 4'($urandom_range(3, 13));
            lo = 4'($urandom_range(0, 15));
            rom[i] = {op, lo};
         end
         run_prog(120);
         end_prog("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
